// File: rtl/branch_resolver_pkg.sv
// Shared constants and types for the branch resolver: opcodes, FSM states, PC width.
package branch_resolver_pkg;

  localparam int unsigned PC_WIDTH = 32;

  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] OP_BEX = 5'b10110;

  typedef enum logic {
    StIdle,
    StFlush
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Execute-stage branch inputs and resolver feedback/redirect/flush outputs.
interface branch_resolver_if;
  import branch_resolver_pkg::*;

  logic                x_valid;
  logic [4:0]          x_opcode;
  logic [PC_WIDTH-1:0] x_pc;
  logic [PC_WIDTH-1:0] x_target;
  logic [31:0]         x_op_a;
  logic [31:0]         x_op_b;
  logic                x_predicted_taken;

  logic [PC_WIDTH-1:0] predictor_past_pc;
  logic                predictor_past_wrong;
  logic                past_predicted_taken;
  logic                past_is_branch;
  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                flush_fd;
  logic                flush_dx;
  logic [31:0]         stat_branches;
  logic [31:0]         stat_mispredicts;

  modport master (
    output x_valid, x_opcode, x_pc, x_target, x_op_a, x_op_b, x_predicted_taken,
    input  predictor_past_pc, predictor_past_wrong, past_predicted_taken, past_is_branch,
    input  redirect, redirect_pc, flush_fd, flush_dx, stat_branches, stat_mispredicts
  );

  modport slave (
    input  x_valid, x_opcode, x_pc, x_target, x_op_a, x_op_b, x_predicted_taken,
    output predictor_past_pc, predictor_past_wrong, past_predicted_taken, past_is_branch,
    output redirect, redirect_pc, flush_fd, flush_dx, stat_branches, stat_mispredicts
  );

endinterface

// File: rtl/branch_compare.sv
// Combinational branch decode and actual-outcome evaluation.
module branch_compare
  import branch_resolver_pkg::*;
(
  input  logic [4:0]  opcode_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic        is_branch_o,
  output logic        taken_o
);

  always_comb begin
    is_branch_o = 1'b0;
    taken_o     = 1'b0;
    case (opcode_i)
      OP_BNE: begin
        is_branch_o = 1'b1;
        taken_o     = (op_a_i != op_b_i);
      end
      OP_BLT: begin
        is_branch_o = 1'b1;
        taken_o     = ($signed(op_a_i) < $signed(op_b_i));
      end
      // bex tests rstatus, which arrives on operand B
      OP_BEX: begin
        is_branch_o = 1'b1;
        taken_o     = (op_b_i != 32'd0);
      end
      default: begin
        is_branch_o = 1'b0;
        taken_o     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves execute-stage branches: predictor feedback, fetch redirect, pipeline flush FSM.
// Optional macro BRANCH_STATS_EN enables saturating branch/mispredict counters.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic              clock,
  input logic              reset,
  branch_resolver_if.slave bus
);

  localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES - 1);

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                is_branch, taken;
  logic                res_event, mispredict;
  logic [PC_WIDTH-1:0] past_pc_q;
  logic                past_wrong_q, past_pred_q, past_is_branch_q;
  logic                redirect_q;
  logic [PC_WIDTH-1:0] redirect_pc_q;

  branch_compare u_compare (
    .opcode_i    (bus.x_opcode),
    .op_a_i      (bus.x_op_a),
    .op_b_i      (bus.x_op_b),
    .is_branch_o (is_branch),
    .taken_o     (taken)
  );

  // Branches seen while flushing are wrong-path and never count as events
  assign res_event  = bus.x_valid & is_branch & (state_q == StIdle);
  assign mispredict = res_event & (taken != bus.x_predicted_taken);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mispredict) begin
          state_d = StFlush;
          cnt_d   = FlushInit;
        end
      end
      StFlush: begin
        if (cnt_q == 3'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= StIdle;
      cnt_q            <= 3'd0;
      past_pc_q        <= '0;
      past_wrong_q     <= 1'b0;
      past_pred_q      <= 1'b0;
      past_is_branch_q <= 1'b0;
      redirect_q       <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      past_is_branch_q <= res_event;
      redirect_q       <= mispredict;
      if (res_event) begin
        past_pc_q    <= bus.x_pc;
        past_wrong_q <= mispredict;
        past_pred_q  <= bus.x_predicted_taken;
      end
      if (mispredict) begin
        redirect_pc_q <= taken ? bus.x_target : bus.x_pc + 32'd1;
      end
    end
  end

  assign bus.predictor_past_pc    = past_pc_q;
  assign bus.predictor_past_wrong = past_wrong_q;
  assign bus.past_predicted_taken = past_pred_q;
  assign bus.past_is_branch       = past_is_branch_q;
  assign bus.redirect             = redirect_q;
  assign bus.redirect_pc          = redirect_pc_q;
  assign bus.flush_fd             = (state_q == StFlush);
  assign bus.flush_dx             = (state_q == StFlush);

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_q, stat_mispredicts_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_branches_q    <= 32'd0;
      stat_mispredicts_q <= 32'd0;
    end else begin
      if (res_event) begin
        stat_branches_q <= sat_inc(stat_branches_q);
      end
      if (mispredict) begin
        stat_mispredicts_q <= sat_inc(stat_mispredicts_q);
      end
    end
  end

  assign bus.stat_branches    = stat_branches_q;
  assign bus.stat_mispredicts = stat_mispredicts_q;
`else
  assign bus.stat_branches    = 32'd0;
  assign bus.stat_mispredicts = 32'd0;
`endif

endmodule
